// File: rtl/mat_mem_server_pkg.sv
// Shared sizes, address widths and state encoding for the matrix-multiply memory server and engine.
package mat_mem_server_pkg;

    localparam int unsigned ROWS_A  = 16;
    localparam int unsigned COLS_A  = 49;
    localparam int unsigned COLS_B  = 32;

    localparam int unsigned A_DEPTH = ROWS_A * COLS_A;   // 784
    localparam int unsigned B_DEPTH = COLS_A * COLS_B;   // 1568
    localparam int unsigned C_DEPTH = ROWS_A * COLS_B;   // 512

    localparam int unsigned AW_A    = 10;
    localparam int unsigned AW_B    = 11;
    localparam int unsigned AW_C    = 9;
    localparam int unsigned PTR_W   = AW_B;
    localparam int unsigned WCNT_W  = 10;

    localparam int unsigned OP_W    = 16;
    localparam int unsigned RES_W   = 32;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        RUN    = 2'd2,
        UNLOAD = 2'd3
    } srv_state_t;

endpackage

// File: rtl/mat_mem_array.sv
// Width/depth-parameterised array: synchronous write, combinational read returning zero out of range.
module mat_mem_array
    import mat_mem_server_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 784,
    parameter int unsigned AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (32'(raddr) < DEPTH) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/mat_mem_server.sv
// Host-stream loader, engine read/write server and result streamer for the 16x49 * 49x32 multiply.
// Optional write-count check is enabled with `define MAT_SRV_WCNT_CHECK_EN.
module mat_mem_server
    import mat_mem_server_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   in_data,
    output logic              in_ready,
    output logic              mm_start,
    input  logic [AW_A-1:0]   addr_a,
    output logic [OP_W-1:0]   data_a,
    input  logic [AW_B-1:0]   addr_b,
    output logic [OP_W-1:0]   data_b,
    input  logic [AW_C-1:0]   addr_c,
    input  logic [RES_W-1:0]  data_c,
    input  logic              we_c,
    input  logic              mm_done,
    output logic              out_valid,
    output logic [RES_W-1:0]  out_data,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              err
);

    localparam logic [PTR_W-1:0] A_LAST = PTR_W'(A_DEPTH - 1);
    localparam logic [PTR_W-1:0] B_LAST = PTR_W'(B_DEPTH - 1);
    localparam logic [AW_C-1:0]  C_LAST = AW_C'(C_DEPTH - 1);

    srv_state_t        state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [AW_C-1:0]   rd_ptr;
    logic              we_a;
    logic              we_b;
    logic              we_mem_c;
    logic              b_done;

    always_comb begin
        we_a     = (state == LOAD_A) && in_valid;
        we_b     = (state == LOAD_B) && in_valid;
        we_mem_c = (state == RUN) && we_c;
        b_done   = we_b && (wr_ptr == B_LAST);
    end

    assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign busy      = (state != LOAD_A);
    assign out_valid = (state == UNLOAD);
    assign out_last  = (state == UNLOAD) && (rd_ptr == C_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= LOAD_A;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mm_start <= 1'b0;
        end else begin
            mm_start <= 1'b0;
            unique case (state)
                LOAD_A: begin
                    if (we_a) begin
                        if (wr_ptr == A_LAST) begin
                            wr_ptr <= '0;
                            state  <= LOAD_B;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (we_b) begin
                        if (b_done) begin
                            wr_ptr   <= '0;
                            mm_start <= 1'b1;
                            state    <= RUN;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (mm_done) begin
                        rd_ptr <= '0;
                        state  <= UNLOAD;
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        // rd_ptr wraps 511 -> 0 on the last beat, leaving it cleared for the next pass
                        rd_ptr <= rd_ptr + 1'b1;
                        if (rd_ptr == C_LAST) begin
                            state <= LOAD_A;
                        end
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    mat_mem_array #(.WIDTH(OP_W), .DEPTH(A_DEPTH), .AW(AW_A)) u_mem_a (
        .clk   (clk),
        .we    (we_a),
        .waddr (wr_ptr[AW_A-1:0]),
        .wdata (in_data),
        .raddr (addr_a),
        .rdata (data_a)
    );

    mat_mem_array #(.WIDTH(OP_W), .DEPTH(B_DEPTH), .AW(AW_B)) u_mem_b (
        .clk   (clk),
        .we    (we_b),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (addr_b),
        .rdata (data_b)
    );

    mat_mem_array #(.WIDTH(RES_W), .DEPTH(C_DEPTH), .AW(AW_C)) u_mem_c (
        .clk   (clk),
        .we    (we_mem_c),
        .waddr (addr_c),
        .wdata (data_c),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

`ifdef MAT_SRV_WCNT_CHECK_EN
    localparam logic [WCNT_W-1:0] WCNT_EXP = WCNT_W'(C_DEPTH);

    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_next;
    logic              err_q;

    // a write coinciding with mm_done still counts toward the total
    assign wcnt_next = wcnt + WCNT_W'(we_mem_c);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            if (b_done) begin
                wcnt <= '0;
            end else if (we_mem_c) begin
                wcnt <= wcnt_next;
            end
            if ((state == RUN) && mm_done && (wcnt_next != WCNT_EXP)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
